// File: rtl/dtc_clk_en_seq_if.sv
// Control/status bus between the slow-control register file and the DTC clock-enable sequencer.
interface dtc_clk_en_seq_if;
    logic        seq_start;
    logic        seq_stop;
    logic [39:0] link_mask;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_err;
    logic [1:0]  seq_state;

    modport master (
        output seq_start, seq_stop, link_mask,
        input  seq_busy, seq_done, seq_err, seq_state
    );

    modport slave (
        input  seq_start, seq_stop, link_mask,
        output seq_busy, seq_done, seq_err, seq_state
    );
endinterface

// File: rtl/dtc_clk_en_seq.sv
// Sequenced enable of the 40 per-DTC clock outputs, one link per STEP_CYCLES, to limit FEE inrush.
// Optional lock monitoring (synchronizer, WAIT_LOCK, timeout, lock-loss abort) under DTC_SEQ_LOCKMON_EN.
module dtc_clk_en_seq #(
    parameter int STEP_CYCLES = 1000,
    parameter int LOCK_WAIT   = 100000
) (
    input  logic                   dcsclk,
    input  logic                   rstn,
    dtc_clk_en_seq_if.slave        ctl,
    input  logic                   SerClkLockSt,
    output logic [39:0]            dtc_clk_en
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int LOCK_W = $clog2(LOCK_WAIT + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [5:0]        IDX_LAST  = 6'd39;

`ifdef DTC_SEQ_LOCKMON_EN
    localparam bit LOCKMON = 1'b1;
`else
    localparam bit LOCKMON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        STEP      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t              state;
    logic [5:0]          idx;
    logic [STEP_W-1:0]   step_tmr;
    logic [39:0]         en_r;
    logic                busy_r;
    logic                done_r;
    logic [39:0]         en_kept;
    logic [39:0]         en_bit;

    // Links whose mask bit was cleared drop immediately; re-set bits are not re-added.
    assign en_kept = en_r & ctl.link_mask;
    assign en_bit  = 40'(1) << idx;

`ifdef DTC_SEQ_LOCKMON_EN
    logic              lock_meta;
    logic              lock_s;
    logic [LOCK_W-1:0] lock_tmr;
    logic              err_r;

    always_ff @(posedge dcsclk or negedge rstn) begin
        if (!rstn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= SerClkLockSt;
            lock_s    <= lock_meta;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = SerClkLockSt;
`endif

    always_ff @(posedge dcsclk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            idx      <= '0;
            step_tmr <= '0;
            en_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef DTC_SEQ_LOCKMON_EN
            lock_tmr <= '0;
            err_r    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (ctl.seq_stop) begin
                // Stop outranks start and lock loss in every state.
                state  <= IDLE;
                en_r   <= '0;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        en_r <= '0;
                        if (ctl.seq_start) begin
                            idx      <= '0;
                            step_tmr <= '0;
                            busy_r   <= 1'b1;
`ifdef DTC_SEQ_LOCKMON_EN
                            err_r    <= 1'b0;
                            lock_tmr <= '0;
                            state    <= WAIT_LOCK;
`else
                            state    <= STEP;
`endif
                        end
                    end

                    WAIT_LOCK: begin
`ifdef DTC_SEQ_LOCKMON_EN
                        if (lock_s) begin
                            state <= STEP;
                        end else if (lock_tmr == LOCK_W'(LOCK_WAIT)) begin
                            err_r  <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            lock_tmr <= lock_tmr + LOCK_W'(1);
                        end
`else
                        busy_r <= 1'b0;
                        state  <= IDLE;
`endif
                    end

                    STEP: begin
`ifdef DTC_SEQ_LOCKMON_EN
                        if (!lock_s) begin
                            en_r   <= '0;
                            err_r  <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end else
`endif
                        if (!ctl.link_mask[idx] || (step_tmr == STEP_LAST)) begin
                            // Unpopulated links are skipped in a single cycle.
                            en_r     <= ctl.link_mask[idx] ? (en_kept | en_bit) : en_kept;
                            step_tmr <= '0;
                            if (idx == IDX_LAST) begin
                                state  <= RUN;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end else begin
                                idx <= idx + 6'd1;
                            end
                        end else begin
                            en_r     <= en_kept;
                            step_tmr <= step_tmr + STEP_W'(1);
                        end
                    end

                    RUN: begin
`ifdef DTC_SEQ_LOCKMON_EN
                        if (!lock_s) begin
                            en_r  <= '0;
                            err_r <= 1'b1;
                            state <= IDLE;
                        end else
`endif
                        begin
                            en_r <= en_kept;
                        end
                    end

                    default: begin
                        en_r   <= '0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign dtc_clk_en    = en_r;
    assign ctl.seq_busy  = busy_r;
    assign ctl.seq_done  = done_r;
    assign ctl.seq_state = state;
`ifdef DTC_SEQ_LOCKMON_EN
    assign ctl.seq_err   = err_r;
`else
    assign ctl.seq_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dtc_clk_en_seq.sv
// Directed bench for dtc_clk_en_seq with STEP_CYCLES=4, LOCK_WAIT=10; adapts latency to the lock-monitor build.
module tb_dtc_clk_en_seq;

    logic        dcsclk = 1'b0;
    logic        rstn;
    logic        lock;
    logic [39:0] en;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          lm;
    int          off;

    dtc_clk_en_seq_if ctl();

    dtc_clk_en_seq #(.STEP_CYCLES(4), .LOCK_WAIT(10)) dut (
        .dcsclk      (dcsclk),
        .rstn        (rstn),
        .ctl         (ctl),
        .SerClkLockSt(lock),
        .dtc_clk_en  (en)
    );

    always #5 dcsclk = ~dcsclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge dcsclk);
        #1;
    endtask

    task automatic start_seq();
        ctl.seq_start = 1'b1;
        tick();
        ctl.seq_start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        lock = 1'b1;
        ctl.seq_start = 1'b0;
        ctl.seq_stop  = 1'b0;
        ctl.link_mask = '0;
        repeat (3) tick();
        n_checks++; if (en !== 40'd0) begin n_fail++; $display("FAIL reset_en: got %h want 0", en); end
        n_checks++; if (ctl.seq_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", ctl.seq_state); end
        n_checks++; if (ctl.seq_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ctl.seq_busy); end
        n_checks++; if (ctl.seq_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ctl.seq_done); end
        n_checks++; if (ctl.seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", ctl.seq_err); end
        rstn = 1'b1;
        repeat (4) tick();
        n_checks++; if (ctl.seq_state !== 2'd0) begin n_fail++; $display("FAIL idle_after_reset: got %0d want 0", ctl.seq_state); end
    endtask

    task automatic test_full_seq();
        logic [39:0] exp_en;
        logic [1:0]  exp_st;
        ctl.link_mask = '1;
        start_seq();
        for (int e = 1; e <= off + 165; e++) begin
            if (e > 1) tick();
            exp_en = '0;
            for (int i = 0; i < 40; i++) if (e >= off + 4 * (i + 1)) exp_en[i] = 1'b1;
            exp_st = (e < off) ? 2'd1 : (e < off + 160) ? 2'd2 : 2'd3;
            n_checks++; if (en !== exp_en) begin n_fail++; $display("FAIL full_en e=%0d: got %h want %h", e, en, exp_en); end
            n_checks++; if (ctl.seq_state !== exp_st) begin n_fail++; $display("FAIL full_state e=%0d: got %0d want %0d", e, ctl.seq_state, exp_st); end
            n_checks++; if (ctl.seq_done !== (e == off + 160)) begin n_fail++; $display("FAIL full_done e=%0d: got %b want %b", e, ctl.seq_done, (e == off + 160)); end
            n_checks++; if (ctl.seq_busy !== (exp_st == 2'd1 || exp_st == 2'd2)) begin n_fail++; $display("FAIL full_busy e=%0d: got %b", e, ctl.seq_busy); end
        end
    endtask

    task automatic test_mask_clear();
        logic [39:0] want;
        want = ~(40'd1 << 5);
        ctl.link_mask[5] = 1'b0;
        tick();
        n_checks++; if (en !== want) begin n_fail++; $display("FAIL mask_clear: got %h want %h", en, want); end
        ctl.link_mask[5] = 1'b1;
        repeat (3) tick();
        n_checks++; if (en !== want) begin n_fail++; $display("FAIL mask_reset_no_add: got %h want %h", en, want); end
        n_checks++; if (ctl.seq_state !== 2'd3) begin n_fail++; $display("FAIL mask_state: got %0d want 3", ctl.seq_state); end
    endtask

    task automatic test_lock_loss();
        logic [39:0] held;
        held = ~(40'd1 << 5);
        lock = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (lm && e == 3) begin
                n_checks++; if (en !== 40'd0) begin n_fail++; $display("FAIL lockloss_en: got %h want 0", en); end
                n_checks++; if (ctl.seq_err !== 1'b1) begin n_fail++; $display("FAIL lockloss_err: got %b want 1", ctl.seq_err); end
                n_checks++; if (ctl.seq_state !== 2'd0) begin n_fail++; $display("FAIL lockloss_state: got %0d want 0", ctl.seq_state); end
            end else begin
                n_checks++; if (en !== held) begin n_fail++; $display("FAIL lockloss_hold e=%0d: got %h want %h", e, en, held); end
                n_checks++; if (ctl.seq_err !== 1'b0) begin n_fail++; $display("FAIL lockloss_err_early e=%0d: got %b want 0", e, ctl.seq_err); end
            end
        end
        if (!lm) begin
            ctl.seq_stop = 1'b1;
            tick();
            ctl.seq_stop = 1'b0;
            n_checks++; if (en !== 40'd0) begin n_fail++; $display("FAIL stop_run_en: got %h want 0", en); end
        end
    endtask

    task automatic test_lock_timeout();
        logic [1:0] exp_st;
        repeat (3) tick();
        start_seq();
        n_checks++; if (ctl.seq_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_cleared: got %b want 0", ctl.seq_err); end
        n_checks++; if (ctl.seq_busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy: got %b want 1", ctl.seq_busy); end
        if (lm) begin
            for (int e = 2; e <= 13; e++) begin
                tick();
                exp_st = (e < 12) ? 2'd1 : 2'd0;
                n_checks++; if (ctl.seq_state !== exp_st) begin n_fail++; $display("FAIL timeout_state e=%0d: got %0d want %0d", e, ctl.seq_state, exp_st); end
                n_checks++; if (ctl.seq_err !== (e >= 12)) begin n_fail++; $display("FAIL timeout_err e=%0d: got %b want %b", e, ctl.seq_err, (e >= 12)); end
                n_checks++; if (en !== 40'd0) begin n_fail++; $display("FAIL timeout_en e=%0d: got %h want 0", e, en); end
            end
        end else begin
            n_checks++; if (ctl.seq_state !== 2'd2) begin n_fail++; $display("FAIL nolock_step: got %0d want 2", ctl.seq_state); end
            ctl.seq_stop = 1'b1;
            tick();
            ctl.seq_stop = 1'b0;
            n_checks++; if (ctl.seq_state !== 2'd0) begin n_fail++; $display("FAIL nolock_stop: got %0d want 0", ctl.seq_state); end
        end
        lock = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_sparse();
        logic [39:0] exp_en;
        logic [1:0]  exp_st;
        ctl.link_mask = 40'd1 << 39;
        start_seq();
        n_checks++; if (ctl.seq_err !== 1'b0) begin n_fail++; $display("FAIL sparse_err_cleared: got %b want 0", ctl.seq_err); end
        for (int e = 1; e <= off + 46; e++) begin
            if (e > 1) tick();
            exp_en = (e >= off + 43) ? (40'd1 << 39) : 40'd0;
            exp_st = (e < off) ? 2'd1 : (e < off + 43) ? 2'd2 : 2'd3;
            n_checks++; if (en !== exp_en) begin n_fail++; $display("FAIL sparse_en e=%0d: got %h want %h", e, en, exp_en); end
            n_checks++; if (ctl.seq_state !== exp_st) begin n_fail++; $display("FAIL sparse_state e=%0d: got %0d want %0d", e, ctl.seq_state, exp_st); end
            n_checks++; if (ctl.seq_done !== (e == off + 43)) begin n_fail++; $display("FAIL sparse_done e=%0d: got %b", e, ctl.seq_done); end
        end
        ctl.seq_stop = 1'b1;
        tick();
        ctl.seq_stop = 1'b0;
    endtask

    task automatic test_stop_collision();
        logic [39:0] exp_en;
        logic [1:0]  exp_st;
        ctl.link_mask = '1;
        start_seq();
        for (int e = 1; e <= off + 14; e++) begin
            if (e > 1) tick();
            exp_en = '0;
            for (int i = 0; i < 40; i++) if (e >= off + 4 * (i + 1)) exp_en[i] = 1'b1;
            exp_st = (e < off) ? 2'd1 : 2'd2;
            if (e == off + 14) begin
                exp_en = '0;
                exp_st = 2'd0;
                n_checks++; if (ctl.seq_busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b want 0", ctl.seq_busy); end
            end
            n_checks++; if (en !== exp_en) begin n_fail++; $display("FAIL stop_en e=%0d: got %h want %h", e, en, exp_en); end
            n_checks++; if (ctl.seq_state !== exp_st) begin n_fail++; $display("FAIL stop_state e=%0d: got %0d want %0d", e, ctl.seq_state, exp_st); end
            ctl.seq_start = (e == off + 5);
            ctl.seq_stop  = (e == off + 13);
        end
        ctl.seq_start = 1'b1;
        ctl.seq_stop  = 1'b1;
        tick();
        ctl.seq_start = 1'b0;
        ctl.seq_stop  = 1'b0;
        for (int e = 0; e < 3; e++) begin
            n_checks++; if (ctl.seq_state !== 2'd0) begin n_fail++; $display("FAIL collide_state e=%0d: got %0d want 0", e, ctl.seq_state); end
            n_checks++; if (ctl.seq_busy !== 1'b0) begin n_fail++; $display("FAIL collide_busy e=%0d: got %b want 0", e, ctl.seq_busy); end
            n_checks++; if (en !== 40'd0) begin n_fail++; $display("FAIL collide_en e=%0d: got %h want 0", e, en); end
            tick();
        end
    endtask

    task automatic test_zero_mask();
        logic [1:0] exp_st;
        ctl.link_mask = '0;
        start_seq();
        for (int e = 1; e <= off + 42; e++) begin
            if (e > 1) tick();
            exp_st = (e < off) ? 2'd1 : (e < off + 40) ? 2'd2 : 2'd3;
            n_checks++; if (ctl.seq_done !== (e == off + 40)) begin n_fail++; $display("FAIL zero_done e=%0d: got %b", e, ctl.seq_done); end
            n_checks++; if (ctl.seq_state !== exp_st) begin n_fail++; $display("FAIL zero_state e=%0d: got %0d want %0d", e, ctl.seq_state, exp_st); end
            n_checks++; if (en !== 40'd0) begin n_fail++; $display("FAIL zero_en e=%0d: got %h want 0", e, en); end
        end
    endtask

    initial begin
        lm  = (dut.LOCKMON != 1'b0);
        off = lm ? 2 : 1;
        test_reset();
        test_full_seq();
        test_mask_clear();
        test_lock_loss();
        test_lock_timeout();
        test_sparse();
        test_stop_collision();
        test_zero_mask();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
